// File: rtl/stop_pipe_pkg.sv
// Shared definitions for the stop/drain controller: channel state encoding and default widths.
package stop_pipe_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_STOP  = 2'd2;

    localparam int DEF_CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRAIN = ST_DRAIN,
        S_STOP  = ST_STOP
    } state_e;

endpackage

// File: rtl/stop_pipe_ctrl_if.sv
// Request/status bundle between a pipeline supervisor (master) and the stop controller (slave).
interface stop_pipe_ctrl_if #(
    parameter int N_CH = 4,
    parameter int CW   = 4
) ();

    logic [N_CH-1:0]    stop_req;
    logic [N_CH-1:0]    resume;
    logic [N_CH*CW-1:0] drain_len;
    logic [N_CH-1:0]    stop;
    logic [N_CH-1:0]    draining;
    logic [N_CH-1:0]    stop_done;
    logic               all_stopped;

    modport master (
        output stop_req, resume, drain_len,
        input  stop, draining, stop_done, all_stopped
    );

    modport slave (
        input  stop_req, resume, drain_len,
        output stop, draining, stop_done, all_stopped
    );

endinterface

// File: rtl/stop_pipe_chan.sv
// One stop/drain channel: latches its drain length on request, counts it down, then holds
// stop until a resume arrives with the request released.
module stop_pipe_chan
    import stop_pipe_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter bit ABORT_EN = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stop_req_i,
    input  logic          resume_i,
    input  logic [CW-1:0] drain_len_i,
    output logic          stop_o,
    output logic          draining_o,
    output logic          stop_done_o
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          stop_q, stop_d;
    logic          draining_q, draining_d;
    logic          done_q, done_d;

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            stop_q     <= 1'b0;
            draining_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            stop_q     <= stop_d;
            draining_q <= draining_d;
            done_q     <= done_d;
        end
    end

    // Next state; outputs are derived from the next state so they land registered
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (stop_req_i) begin
                    count_d = drain_len_i;
                    if (drain_len_i == '0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (ABORT_EN && !stop_req_i) begin
                    state_d = S_IDLE;
                end else if (count_q <= CW'(1)) begin
                    // Exit at 1 (or a stray 0) so the counter can never wrap
                    state_d = S_STOP;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_STOP: begin
                if (resume_i && !stop_req_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        stop_d     = (state_d == S_STOP);
        draining_d = (state_d == S_DRAIN);
        done_d     = (state_d == S_STOP) && (state_q != S_STOP);
    end

    assign stop_o      = stop_q;
    assign draining_o  = draining_q;
    assign stop_done_o = done_q;

endmodule

// File: rtl/stop_pipe_ctrl.sv
// Multi-channel pipeline stop/drain controller: N_CH independent channels plus an
// aggregate flag that is high only while every channel holds stop.
module stop_pipe_ctrl
    import stop_pipe_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CW       = DEF_CW,
    parameter bit ABORT_EN = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    stop_pipe_ctrl_if.slave ctrl_io
);

    logic [N_CH-1:0] stop_s;
    logic [N_CH-1:0] draining_s;
    logic [N_CH-1:0] done_s;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        stop_pipe_chan #(
            .CW       (CW),
            .ABORT_EN (ABORT_EN)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .stop_req_i  (ctrl_io.stop_req[i]),
            .resume_i    (ctrl_io.resume[i]),
            .drain_len_i (ctrl_io.drain_len[i*CW +: CW]),
            .stop_o      (stop_s[i]),
            .draining_o  (draining_s[i]),
            .stop_done_o (done_s[i])
        );
    end

    assign ctrl_io.stop        = stop_s;
    assign ctrl_io.draining    = draining_s;
    assign ctrl_io.stop_done   = done_s;
    assign ctrl_io.all_stopped = &stop_s;

endmodule

// File: tb/tb_stop_pipe_ctrl.sv
// Bench for stop_pipe_ctrl: a drain-always DUT (a) and an abort-enabled DUT (b) share stimulus.
module tb_stop_pipe_ctrl;

    logic clk;
    logic rst;

    stop_pipe_ctrl_if #(.N_CH(4), .CW(4)) if_a ();
    stop_pipe_ctrl_if #(.N_CH(4), .CW(4)) if_b ();

    assign if_b.stop_req  = if_a.stop_req;
    assign if_b.resume    = if_a.resume;
    assign if_b.drain_len = if_a.drain_len;

    stop_pipe_ctrl #(.N_CH(4), .CW(4), .ABORT_EN(1'b0)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_io (if_a.slave)
    );

    stop_pipe_ctrl #(.N_CH(4), .CW(4), .ABORT_EN(1'b1)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .ctrl_io (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  res;
        logic [15:0] len;
        logic [3:0]  e_stop;
        logic [3:0]  e_drn;
        logic [3:0]  e_done;
        logic        e_all;
    } vec_t;

    localparam int NV = 29;
    vec_t vec [NV];

    int checks;
    int errors;

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] res, input logic [15:0] len);
        rst            = r;
        if_a.stop_req  = req;
        if_a.resume    = res;
        if_a.drain_len = len;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input int row, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] p, input logic a);
        chk({nm, "_stop"}, row, 16'(if_a.stop), 16'(s));
        chk({nm, "_drn"},  row, 16'(if_a.draining), 16'(d));
        chk({nm, "_done"}, row, 16'(if_a.stop_done), 16'(p));
        chk({nm, "_all"},  row, 16'(if_a.all_stopped), 16'(a));
    endtask

    task automatic chk_b(input string nm, input int row, input logic [3:0] s, input logic [3:0] d,
                         input logic [3:0] p, input logic a);
        chk({nm, "_stop"}, row, 16'(if_b.stop), 16'(s));
        chk({nm, "_drn"},  row, 16'(if_b.draining), 16'(d));
        chk({nm, "_done"}, row, 16'(if_b.stop_done), 16'(p));
        chk({nm, "_all"},  row, 16'(if_b.all_stopped), 16'(a));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // rst, req, res, len, exp stop, exp draining, exp done, exp all  (state after the edge)
        vec[0]  = '{1'b1, 4'hF, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[1]  = '{1'b1, 4'hF, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[2]  = '{1'b0, 4'h0, 4'h0, 16'h0003, 4'h0, 4'h0, 4'h0, 1'b0};
        // ch0 drain length 3
        vec[3]  = '{1'b0, 4'h1, 4'h0, 16'h0003, 4'h0, 4'h1, 4'h0, 1'b0};
        vec[4]  = '{1'b0, 4'h1, 4'h0, 16'h0003, 4'h0, 4'h1, 4'h0, 1'b0};
        vec[5]  = '{1'b0, 4'h1, 4'h0, 16'h0003, 4'h0, 4'h1, 4'h0, 1'b0};
        vec[6]  = '{1'b0, 4'h1, 4'h0, 16'h0003, 4'h1, 4'h0, 4'h1, 1'b0};
        vec[7]  = '{1'b0, 4'h1, 4'h0, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b0};
        // resume while still requested is ignored, then released
        vec[8]  = '{1'b0, 4'h1, 4'h1, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b0};
        vec[9]  = '{1'b0, 4'h0, 4'h1, 16'h0003, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[10] = '{1'b0, 4'h0, 4'h0, 16'h0003, 4'h0, 4'h0, 4'h0, 1'b0};
        // re-drain with length 2
        vec[11] = '{1'b0, 4'h1, 4'h0, 16'h0002, 4'h0, 4'h1, 4'h0, 1'b0};
        vec[12] = '{1'b0, 4'h1, 4'h0, 16'h0002, 4'h0, 4'h1, 4'h0, 1'b0};
        vec[13] = '{1'b0, 4'h1, 4'h0, 16'h0002, 4'h1, 4'h0, 4'h1, 1'b0};
        vec[14] = '{1'b0, 4'h0, 4'h1, 16'h0002, 4'h0, 4'h0, 4'h0, 1'b0};
        // zero length stops on the request edge
        vec[15] = '{1'b0, 4'h1, 4'h0, 16'h0000, 4'h1, 4'h0, 4'h1, 1'b0};
        vec[16] = '{1'b0, 4'h0, 4'h1, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[17] = '{1'b0, 4'h0, 4'h0, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0};
        // four channels, lengths 1..4, length bus rewritten mid-drain
        vec[18] = '{1'b0, 4'hF, 4'h0, 16'h4321, 4'h0, 4'hF, 4'h0, 1'b0};
        vec[19] = '{1'b0, 4'hF, 4'h0, 16'hFFFF, 4'h1, 4'hE, 4'h1, 1'b0};
        vec[20] = '{1'b0, 4'hF, 4'h0, 16'hFFFF, 4'h3, 4'hC, 4'h2, 1'b0};
        vec[21] = '{1'b0, 4'hF, 4'h0, 16'hFFFF, 4'h7, 4'h8, 4'h4, 1'b0};
        vec[22] = '{1'b0, 4'hF, 4'h0, 16'hFFFF, 4'hF, 4'h0, 4'h8, 1'b1};
        vec[23] = '{1'b0, 4'hF, 4'h0, 16'hFFFF, 4'hF, 4'h0, 4'h0, 1'b1};
        vec[24] = '{1'b0, 4'h0, 4'hF, 16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0};
        // reset mid-drain
        vec[25] = '{1'b0, 4'hF, 4'h0, 16'h5555, 4'h0, 4'hF, 4'h0, 1'b0};
        vec[26] = '{1'b0, 4'hF, 4'h0, 16'h5555, 4'h0, 4'hF, 4'h0, 1'b0};
        vec[27] = '{1'b1, 4'hF, 4'h0, 16'h5555, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[28] = '{1'b0, 4'h0, 4'h0, 16'h5555, 4'h0, 4'h0, 4'h0, 1'b0};

        drive(1'b1, 4'hF, 4'h0, 16'h0000);
        #1;
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].rst, vec[i].req, vec[i].res, vec[i].len);
            step();
            chk_a("tab_a", i, vec[i].e_stop, vec[i].e_drn, vec[i].e_done, vec[i].e_all);
            chk_b("tab_b", i, vec[i].e_stop, vec[i].e_drn, vec[i].e_done, vec[i].e_all);
        end

        // Maximum length 15: stop exactly after edge k+15, draining before that
        drive(1'b0, 4'h1, 4'h0, 16'h000F);
        step();
        chk_a("max_k", 0, 4'h0, 4'h1, 4'h0, 1'b0);
        for (int j = 1; j < 15; j++) begin
            step();
            chk_a("max_mid", j, 4'h0, 4'h1, 4'h0, 1'b0);
        end
        step();
        chk_a("max_end", 15, 4'h1, 4'h0, 4'h1, 1'b0);
        drive(1'b0, 4'h0, 4'h1, 16'h000F);
        step();
        chk_a("max_rel", 16, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 16'h0000);
        step();

        // Abort: length 5, request dropped at the 2nd DRAIN edge
        drive(1'b0, 4'h1, 4'h0, 16'h0005);
        step();
        chk_a("abt_k_a", 0, 4'h0, 4'h1, 4'h0, 1'b0);
        chk_b("abt_k_b", 0, 4'h0, 4'h1, 4'h0, 1'b0);
        step();
        drive(1'b0, 4'h0, 4'h0, 16'h0005);
        step();
        chk_a("abt_k2_a", 2, 4'h0, 4'h1, 4'h0, 1'b0);
        chk_b("abt_k2_b", 2, 4'h0, 4'h0, 4'h0, 1'b0);
        step();
        step();
        chk_a("abt_k4_a", 4, 4'h0, 4'h1, 4'h0, 1'b0);
        chk_b("abt_k4_b", 4, 4'h0, 4'h0, 4'h0, 1'b0);
        step();
        chk_a("abt_k5_a", 5, 4'h1, 4'h0, 4'h1, 1'b0);
        chk_b("abt_k5_b", 5, 4'h0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 4'h1, 16'h0005);
        step();
        chk_a("abt_rel_a", 6, 4'h0, 4'h0, 4'h0, 1'b0);
        chk_b("abt_rel_b", 6, 4'h0, 4'h0, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
